// File: rtl/edulent_pkg.sv
// Shared constants and loader state encoding for the Edulent core and its memory.
package edulent_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int MEM_AW    = 8;
    localparam logic [7:0] STACK_TOP = 8'h7F;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/edulent_ram.sv
// Byte array with one synchronous write port and one asynchronous read port.
module edulent_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are deliberately never reset so a reset cannot erase a loaded program.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/edulent_mem.sv
// Memory responder for the Edulent core: 256-byte unified RAM plus a byte-serial
// program loader that holds the core in reset while filling memory.
module edulent_mem
    import edulent_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = MEM_AW
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_mem_addr,
    input  logic [7:0] i_mem_data_write,
    input  logic       i_mem_write_enable,
    output logic [7:0] o_mem_data_read,
    input  logic       i_ld_start,
    input  logic       i_ld_valid,
    input  logic [7:0] i_ld_data,
    input  logic       i_ld_last,
    output logic       o_ld_ready,
    output logic [8:0] o_ld_count,
    output logic       o_ld_err,
    output logic       o_cpu_rstn
);

    ld_state_t     state;
    logic [AW-1:0] ld_addr;
    logic [8:0]    ld_count;
    logic          ld_err;
    logic          ld_ready;
    logic          cpu_rstn;

    logic          ld_accept;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    assign ld_accept = i_ld_valid & ld_ready;

    // ld_ready and cpu_rstn are registered alongside the state so they never glitch.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= RUN;
            ld_addr  <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
            ld_ready <= 1'b0;
            cpu_rstn <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (i_ld_start) begin
                        state    <= LOAD;
                        ld_addr  <= '0;
                        ld_count <= '0;
                        ld_err   <= 1'b0;
                        ld_ready <= 1'b1;
                        cpu_rstn <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_accept) begin
                        ld_addr <= ld_addr + 1'b1;
                        if (ld_count != 9'(DEPTH)) begin
                            ld_count <= ld_count + 9'd1;
                        end
                        // DEPTH is a power of two, so all-ones is the wrap point.
                        if ((&ld_addr) && !i_ld_last) begin
                            ld_err <= 1'b1;
                        end
                        if (i_ld_last) begin
                            state    <= RELEASE;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    state    <= RUN;
                    cpu_rstn <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    ld_ready <= 1'b0;
                    cpu_rstn <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = i_mem_addr[AW-1:0];
        ram_wdata = i_mem_data_write;
        if (state == RUN) begin
            ram_we = i_mem_write_enable;
        end else if (ld_accept) begin
            ram_we    = 1'b1;
            ram_waddr = ld_addr;
            ram_wdata = i_ld_data;
        end
    end

    edulent_ram #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .raddr(i_mem_addr[AW-1:0]),
        .rdata(ram_rdata)
    );

    assign o_mem_data_read = (state == LOAD) ? 8'h00 : ram_rdata;
    assign o_ld_ready      = ld_ready;
    assign o_ld_count      = ld_count;
    assign o_ld_err        = ld_err;
    assign o_cpu_rstn      = cpu_rstn;

endmodule

// File: tb/tb_edulent_mem.sv
// Directed self-checking bench for edulent_mem: core port, loader, overflow and reset cases.
module tb_edulent_mem;
    import edulent_pkg::*;

    logic       clk;
    logic       rstn;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [8:0] ld_count;
    logic       ld_err;
    logic       cpu_rstn;

    int tests;
    int fails;

    edulent_mem dut (
        .i_clk             (clk),
        .i_rstn            (rstn),
        .i_mem_addr        (mem_addr),
        .i_mem_data_write  (mem_wdata),
        .i_mem_write_enable(mem_we),
        .o_mem_data_read   (mem_rdata),
        .i_ld_start        (ld_start),
        .i_ld_valid        (ld_valid),
        .i_ld_data         (ld_data),
        .i_ld_last         (ld_last),
        .o_ld_ready        (ld_ready),
        .o_ld_count        (ld_count),
        .o_ld_err          (ld_err),
        .o_cpu_rstn        (cpu_rstn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
        mem_addr = a;
        #1;
        chk(tag, 9'(mem_rdata), 9'(exp));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rstn      = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_data   = 8'h00;
        ld_last   = 1'b0;

        #12;
        chk("rst_ready", 9'(ld_ready), 9'd0);
        chk("rst_cpu_rstn", 9'(cpu_rstn), 9'd1);
        chk("rst_count", ld_count, 9'd0);
        chk("rst_err", 9'(ld_err), 9'd0);
        tick();
        rstn = 1'b1;
        tick();

        // Core write, then write again with old data visible while the strobe is high
        mem_addr = 8'h10; mem_wdata = 8'h5A; mem_we = 1'b1;
        tick();
        mem_wdata = 8'hA5;
        #1;
        chk("old_data_during_strobe", 9'(mem_rdata), 9'h05A);
        tick();
        mem_we = 1'b0;
        #1;
        chk("core_wr_rd", 9'(mem_rdata), 9'h0A5);

        // Loader valid while in RUN must not write or count
        mem_addr = 8'h00; mem_wdata = 8'h33; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hFF;
        tick();
        ld_valid = 1'b0;
        chk("run_valid_count", ld_count, 9'd0);
        chk("run_valid_ready", 9'(ld_ready), 9'd0);
        rd(8'h00, "run_valid_nowrite", 8'h33);

        // Start together with a core write: write lands, then LOAD
        mem_addr = 8'h40; mem_wdata = 8'h77; mem_we = 1'b1; ld_start = 1'b1;
        tick();
        mem_we = 1'b0; ld_start = 1'b0;
        #1;
        chk("load_cpu_rstn", 9'(cpu_rstn), 9'd0);
        chk("load_ready", 9'(ld_ready), 9'd1);
        chk("load_read_zero", 9'(mem_rdata), 9'd0);
        ld_valid = 1'b1; ld_data = 8'h11;
        tick();
        ld_valid = 1'b0;
        tick();
        chk("bubble_cpu_rstn", 9'(cpu_rstn), 9'd0);
        chk("bubble_count", ld_count, 9'd1);
        ld_valid = 1'b1; ld_data = 8'h05;
        tick();
        ld_data = 8'h21;
        tick();
        ld_data = 8'h06; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        chk("release_cpu_rstn", 9'(cpu_rstn), 9'd0);
        chk("release_ready", 9'(ld_ready), 9'd0);
        tick();
        chk("run_cpu_rstn", 9'(cpu_rstn), 9'd1);
        chk("load4_count", ld_count, 9'd4);
        chk("load4_err", 9'(ld_err), 9'd0);
        rd(8'h00, "load4_m0", 8'h11);
        rd(8'h01, "load4_m1", 8'h05);
        rd(8'h02, "load4_m2", 8'h21);
        rd(8'h03, "load4_m3", 8'h06);
        rd(8'h40, "start_with_write", 8'h77);

        // Overflow: 257 bytes, last on the 257th
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 257; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 256) ? 8'hC3 : 8'(i);
            ld_last  = (i == 256);
            if (i == 255) chk("pre_wrap_err", 9'(ld_err), 9'd0);
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        tick();
        chk("ovf_err", 9'(ld_err), 9'd1);
        chk("ovf_count_sat", ld_count, 9'h100);
        rd(8'h00, "ovf_m0", 8'hC3);
        rd(8'h01, "ovf_m1", 8'h01);
        rd(8'hFF, "ovf_mff", 8'hFF);

        // Reset in the middle of a load; core write during LOAD is dropped
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("restart_err_clr", 9'(ld_err), 9'd0);
        ld_valid = 1'b1; ld_data = 8'hAA;
        tick();
        ld_data = 8'hBB;
        tick();
        ld_valid = 1'b0;
        mem_addr = 8'h02; mem_wdata = 8'hEE; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_cpu_rstn", 9'(cpu_rstn), 9'd1);
        chk("midrst_ready", 9'(ld_ready), 9'd0);
        chk("midrst_count", ld_count, 9'd0);
        #2;
        rstn = 1'b1;
        tick();
        rd(8'h00, "midrst_m0", 8'hAA);
        rd(8'h01, "midrst_m1", 8'hBB);
        rd(8'h02, "load_core_wr_ignored", 8'h02);

        // Stack push/push/pop/pop
        mem_addr = STACK_TOP; mem_wdata = 8'hD1; mem_we = 1'b1;
        tick();
        mem_addr = STACK_TOP - 8'd1; mem_wdata = 8'hD2;
        tick();
        mem_we = 1'b0;
        rd(STACK_TOP - 8'd1, "pop1", 8'hD2);
        tick();
        rd(STACK_TOP, "pop2", 8'hD1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
